e_mdu_ctrl: RTL and testbench

E_MDU_CTRL -- requirements
Module: e_mdu_ctrl

---
 rtl/mdu_pkg.sv | 36 +++
 rtl/mdu_arith.sv | 63 ++++++
 rtl/e_mdu_ctrl.sv | 128 ++++++++++++
 tb/tb_e_mdu_ctrl.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// ---------------------------------------------------------------------------
// mdu_pkg -- shared definitions for the E-stage multiply/divide unit.
//   md_op_e      : E-stage HI/LO operation encodings (7-15 are treated as none)
//   mdu_state_e  : sequencing FSM states
//   *_CYCLES_DEF : default busy latencies after a mult*/div* start
//   is_mul/is_div: op classification helpers
// ---------------------------------------------------------------------------
package mdu_pkg;

    typedef enum logic [3:0] {
        MD_NONE  = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MTHI  = 4'd5,
        MD_MTLO  = 4'd6
    } md_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } mdu_state_e;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    function automatic logic is_mul(input logic [3:0] op);
        return (op == MD_MULT) || (op == MD_MULTU);
    endfunction

    function automatic logic is_div(input logic [3:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/mdu_arith.sv
// ---------------------------------------------------------------------------
// mdu_arith -- combinational 32x32 multiply and divide.
//   op       : md_op encoding; mult/div signed, multu/divu unsigned
//   a, b     : operands (rs, rt)
//   res_hi   : product high word, or remainder
//   res_lo   : product low word, or quotient
//   div_zero : divisor is zero; results are meaningless and must not be kept
// ---------------------------------------------------------------------------
module mdu_arith
    import mdu_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] res_hi,
    output logic [31:0] res_lo,
    output logic        div_zero
);

    logic        is_signed;
    logic [63:0] a_ext;
    logic [63:0] b_ext;
    logic [63:0] prod;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] b_safe;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic        neg_q;
    logic        neg_r;

    // NOTE: every variable written here gets a value on every path, so no latches are inferred.
    always_comb begin
        is_signed = (op == MD_MULT) || (op == MD_DIV);

        // The low 64 bits of a product of 64-bit extended operands are the
        // exact two's-complement product for either signedness.
        a_ext = is_signed ? {{32{a[31]}}, a} : {32'b0, a};
        b_ext = is_signed ? {{32{b[31]}}, b} : {32'b0, b};
        prod  = a_ext * b_ext;

        // Signed division on magnitudes, then fix signs: quotient negative when
        // operand signs differ, remainder follows the dividend. 0x80000000/-1
        // falls out naturally as LO=0x80000000, HI=0.
        neg_q    = is_signed && (a[31] ^ b[31]);
        neg_r    = is_signed && a[31];
        a_mag    = (is_signed && a[31]) ? -a : a;
        b_mag    = (is_signed && b[31]) ? -b : b;
        div_zero = (b == 32'd0);
        b_safe   = div_zero ? 32'd1 : b_mag;
        q_mag    = a_mag / b_safe;
        r_mag    = a_mag % b_safe;

        if (is_mul(op)) begin
            res_hi = prod[63:32];
            res_lo = prod[31:0];
        end else begin
            res_hi = neg_r ? -r_mag : r_mag;
            res_lo = neg_q ? -q_mag : q_mag;
        end
    end

endmodule

// File: rtl/e_mdu_ctrl.sv
// ---------------------------------------------------------------------------
// e_mdu_ctrl -- E-stage HI/LO unit sequencing with fixed multi-cycle latency.
//   clk, reset : clock; asynchronous active-low reset
//   md_op      : E-stage op (none/mult/multu/div/divu/mthi/mtlo)
//   start      : E-stage mult*/div* is valid this cycle
//   flush      : exception/interrupt; the E-stage op is dropped
//   E_Rs, E_Rt : forwarded operands
//   D_is_md    : D-stage instruction touches HI/LO
//   busy       : operation in flight (MULT_CYCLES or DIV_CYCLES cycles)
//   md_stall   : D stage must stall
//   hi, lo     : architectural HI/LO
// ---------------------------------------------------------------------------
module e_mdu_ctrl
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  md_op,
    input  logic        start,
    input  logic        flush,
    input  logic [31:0] E_Rs,
    input  logic [31:0] E_Rt,
    input  logic        D_is_md,
    output logic        busy,
    output logic        md_stall,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    mdu_state_e       state_q;
    mdu_state_e       state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [31:0]      pend_hi_q;
    logic [31:0]      pend_lo_q;
    logic             pend_wr_q;
    logic [31:0]      hi_q;
    logic [31:0]      lo_q;
    logic [31:0]      res_hi;
    logic [31:0]      res_lo;
    logic             div_zero;
    logic             is_muldiv;
    logic             launch;
    logic             finish;

    mdu_arith u_arith (
        .op      (md_op),
        .a       (E_Rs),
        .b       (E_Rt),
        .res_hi  (res_hi),
        .res_lo  (res_lo),
        .div_zero(div_zero)
    );

    assign is_muldiv = is_mul(md_op) || is_div(md_op);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next state plus the one-cycle launch/finish strobes for the datapath.
    always_comb begin
        state_d = state_q;
        launch  = 1'b0;
        finish  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start && !flush && is_muldiv) begin
                    launch  = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // Counter reaches 0 on this edge: the last busy cycle.
                if (cnt_q == CNT_W'(1)) begin
                    finish  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: pending result registers are reset too, so an op cut short by reset can never write back.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q     <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
            pend_wr_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            if (launch) begin
                cnt_q     <= is_mul(md_op) ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
                pend_hi_q <= res_hi;
                pend_lo_q <= res_lo;
                // Divide by zero still takes the full latency but keeps HI/LO.
                pend_wr_q <= !(is_div(md_op) && div_zero);
            end else if (state_q == ST_RUN) begin
                cnt_q <= cnt_q - CNT_W'(1);
            end

            if (finish) begin
                if (pend_wr_q) begin
                    hi_q <= pend_hi_q;
                    lo_q <= pend_lo_q;
                end
            end else if (state_q == ST_IDLE && !flush) begin
                if (md_op == MD_MTHI) hi_q <= E_Rs;
                if (md_op == MD_MTLO) lo_q <= E_Rs;
            end
        end
    end

    assign busy     = (state_q == ST_RUN);
    assign md_stall = D_is_md & (busy | start);
    assign hi       = hi_q;
    assign lo       = lo_q;

endmodule

// File: tb/tb_e_mdu_ctrl.sv
// ---------------------------------------------------------------------------
// tb_e_mdu_ctrl -- self-checking bench for e_mdu_ctrl.
// Expected HI/LO come from a plain-arithmetic model (64-bit signed/unsigned
// math) and expected latencies from the parameter values.
// ---------------------------------------------------------------------------
module tb_e_mdu_ctrl;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    localparam int OP_NONE  = 0;
    localparam int OP_MULT  = 1;
    localparam int OP_MULTU = 2;
    localparam int OP_DIV   = 3;
    localparam int OP_DIVU  = 4;
    localparam int OP_MTHI  = 5;
    localparam int OP_MTLO  = 6;

    logic        clk     = 1'b0;
    logic        reset   = 1'b0;
    logic [3:0]  md_op   = 4'd0;
    logic        start   = 1'b0;
    logic        flush   = 1'b0;
    logic [31:0] E_Rs    = 32'd0;
    logic [31:0] E_Rt    = 32'd0;
    logic        D_is_md = 1'b0;
    logic        busy;
    logic        md_stall;
    logic [31:0] hi;
    logic [31:0] lo;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] mdl_hi   = 32'd0;
    logic [31:0] mdl_lo   = 32'd0;

    e_mdu_ctrl #(
        .MULT_CYCLES(MULT_N),
        .DIV_CYCLES (DIV_N)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .md_op   (md_op),
        .start   (start),
        .flush   (flush),
        .E_Rs    (E_Rs),
        .E_Rt    (E_Rt),
        .D_is_md (D_is_md),
        .busy    (busy),
        .md_stall(md_stall),
        .hi      (hi),
        .lo      (lo)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Reference result straight from the arithmetic definition.
    function automatic void ref_op(input int op, input logic [31:0] a, input logic [31:0] b,
                                   output bit wr, output logic [31:0] rh, output logic [31:0] rl);
        longint      sa, sb, q, r;
        logic [63:0] p;
        wr = 1'b1;
        rh = 32'd0;
        rl = 32'd0;
        p  = 64'd0;
        if (op == OP_MULT || op == OP_DIV) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        if (op == OP_MULT || op == OP_MULTU) begin
            p  = 64'(sa * sb);
            rh = p[63:32];
            rl = p[31:0];
        end else if (b == 32'd0) begin
            wr = 1'b0;
        end else begin
            q  = sa / sb;
            r  = sa % sb;
            rl = q[31:0];
            rh = r[31:0];
        end
    endfunction

    // All tasks are entered just after a falling edge and return just after one.
    task automatic run_op(input int op, input logic [31:0] a, input logic [31:0] b,
                          input logic dmd, input bit mthi_mid);
        int          n;
        int          cnt;
        bit          wr;
        logic [31:0] rh, rl;
        n = (op == OP_MULT || op == OP_MULTU) ? MULT_N : DIV_N;
        ref_op(op, a, b, wr, rh, rl);
        md_op   = 4'(op);
        start   = 1'b1;
        flush   = 1'b0;
        E_Rs    = a;
        E_Rt    = b;
        D_is_md = dmd;
        #1 check("stall_on_start", 32'(md_stall), 32'(dmd));
        @(negedge clk);
        md_op = 4'd0;
        start = 1'b0;
        cnt   = 0;
        while (busy === 1'b1 && cnt < 40) begin
            cnt++;
            if (dmd) check("stall_while_busy", 32'(md_stall), 32'd1);
            check("hi_hold_in_run", hi, mdl_hi);
            if (cnt == 2 && mthi_mid) begin
                md_op = 4'(OP_MTHI);
                E_Rs  = 32'hDEAD_BEEF;
            end else begin
                md_op = 4'd0;
            end
            @(negedge clk);
        end
        md_op = 4'd0;
        check("busy_cycles", 32'(cnt), 32'(n));
        if (wr) begin
            mdl_hi = rh;
            mdl_lo = rl;
        end
        check("hi_after_op", hi, mdl_hi);
        check("lo_after_op", lo, mdl_lo);
        check("stall_after_busy", 32'(md_stall), 32'd0);
        D_is_md = 1'b0;
    endtask

    task automatic mt(input int op, input logic [31:0] v, input logic fl);
        md_op = 4'(op);
        start = 1'b0;
        flush = fl;
        E_Rs  = v;
        @(negedge clk);
        md_op = 4'd0;
        flush = 1'b0;
        if (!fl && op == OP_MTHI) mdl_hi = v;
        if (!fl && op == OP_MTLO) mdl_lo = v;
        check("mt_busy", 32'(busy), 32'd0);
        check("mt_hi", hi, mdl_hi);
        check("mt_lo", lo, mdl_lo);
    endtask

    task automatic flush_start(input int op, input logic [31:0] a, input logic [31:0] b);
        md_op = 4'(op);
        start = 1'b1;
        flush = 1'b1;
        E_Rs  = a;
        E_Rt  = b;
        @(negedge clk);
        md_op = 4'd0;
        start = 1'b0;
        flush = 1'b0;
        check("flush_busy", 32'(busy), 32'd0);
        repeat (DIV_N + 1) @(negedge clk);
        check("flush_busy_late", 32'(busy), 32'd0);
        check("flush_hi", hi, mdl_hi);
        check("flush_lo", lo, mdl_lo);
    endtask

    initial begin
        int          r;
        logic [31:0] a, b;

        // Reset state.
        #12;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_stall", 32'(md_stall), 32'd0);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);

        // Release and start on the very first edge.
        @(negedge clk);
        reset = 1'b1;
        run_op(OP_MULT, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0);
        check("mult_vec_hi", hi, 32'hFFFF_FFFF);
        check("mult_vec_lo", lo, 32'hFFFF_FFFE);

        run_op(OP_DIVU, 32'd7, 32'd2, 1'b0, 1'b0);
        check("divu_vec_lo", lo, 32'd3);
        check("divu_vec_hi", hi, 32'd1);

        run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
        check("div_vec_lo", lo, 32'hFFFF_FFFD);
        check("div_vec_hi", hi, 32'hFFFF_FFFF);

        // Flushed start and flushed mtlo are dropped.
        flush_start(OP_MULT, 32'd5, 32'd6);
        mt(OP_MTLO, 32'h0000_1234, 1'b1);

        // Stall while busy, mthi during RUN ignored.
        run_op(OP_DIV, 32'd100, 32'd7, 1'b1, 1'b1);

        // Divide by zero keeps preloaded HI/LO.
        mt(OP_MTHI, 32'h0000_000A, 1'b0);
        mt(OP_MTLO, 32'h0000_000B, 1'b0);
        run_op(OP_DIV, 32'd123, 32'd0, 1'b0, 1'b0);
        check("dz_hi", hi, 32'h0000_000A);
        check("dz_lo", lo, 32'h0000_000B);
        run_op(OP_DIVU, 32'd55, 32'd0, 1'b1, 1'b0);

        // Signed overflow case and unsigned max product.
        run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
        check("ovf_lo", lo, 32'h8000_0000);
        check("ovf_hi", hi, 32'd0);
        run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);

        // Reserved op codes do nothing.
        mt(9, 32'h1111_2222, 1'b0);
        mt(15, 32'h3333_4444, 1'b0);

        // Randomized ops against the model.
        for (int i = 0; i < 30; i++) begin
            r = $urandom_range(0, 9);
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 9)) : $urandom;
            case (r)
                0, 1, 2, 3: run_op(r + 1, a, b, 1'($urandom_range(0, 1)), 1'b0);
                4:          mt(OP_MTHI, a, 1'($urandom_range(0, 1)));
                5:          mt(OP_MTLO, a, 1'($urandom_range(0, 1)));
                6:          mt($urandom_range(7, 15), a, 1'b0);
                7:          run_op($urandom_range(OP_DIV, OP_DIVU), a, 32'd0, 1'b0, 1'b0);
                default:    run_op($urandom_range(OP_MULT, OP_DIVU), a, 32'($urandom_range(1, 5)), 1'b0, 1'b1);
            endcase
        end

        // Reset at RUN cycle 3 discards the operation.
        mt(OP_MTHI, 32'h0000_0055, 1'b0);
        md_op = 4'(OP_MULT);
        start = 1'b1;
        E_Rs  = 32'd3;
        E_Rt  = 32'd4;
        @(negedge clk);
        md_op = 4'(OP_NONE);
        start = 1'b0;
        repeat (2) @(negedge clk);
        check("pre_rst_busy", 32'(busy), 32'd1);
        #2 reset = 1'b0;
        #1;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_hi", hi, 32'd0);
        check("mid_rst_lo", lo, 32'd0);
        mdl_hi = 32'd0;
        mdl_lo = 32'd0;
        @(negedge clk);
        reset = 1'b1;
        repeat (MULT_N + 3) @(negedge clk);
        check("post_rst_busy", 32'(busy), 32'd0);
        check("post_rst_hi", hi, 32'd0);
        check("post_rst_lo", lo, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
